bus_mem_responder: RTL
======================

Name: bus_mem_responder

Overview:
- Memory-side responder for the tagged processor bus that the instruction and data caches use to issue requests.
- Accepts BUS_LOAD and BUS_STORE commands and answers in the same cycle with a nonzero 4-bit transaction tag, or with 0 to reject.
- Each accepted load returns its 64-bit data, paired with its tag, a fixed number of cycles later.
- Backing store is a synthesizable 64-bit-word array. The block is used in simulation and on FPGA in place of the behavioural memory.

Parameters:
- MEM_WORDS, 4096, depth of the backing array in 64-bit words; address index is proc2mem_addr[$clog2(MEM_WORDS)+2:3].
- MEM_LATENCY, 4, cycles from load acceptance to data return; legal range 1..14.
- BP_PERIOD, 5, backpressure period (used only with MEM_BACKPRESSURE_EN); legal range 2..15.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- proc2mem_command  input  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is treated as BUS_NONE
- proc2mem_addr  input  64  byte address; bits [2:0] ignored
- proc2mem_data  input  64  store data
- mem2proc_response  output  4  combinational; tag of the accepted request, 0 = rejected or idle
- mem2proc_data  output  64  registered load return data
- mem2proc_tag  output  4  registered; nonzero for exactly one cycle per completed load

Behaviour:
- Reset:
  - mem2proc_tag=0 and mem2proc_data=0 from the first clock edge with reset high.
  - mem2proc_response=0 while reset is high.
  - All tags 1..15 marked free; in-flight pipeline cleared.
  - Array contents are not reset.
- Reset mid-operation: every in-flight load is discarded, its tag is never broadcast, and no write is lost or duplicated.
- Acceptance (combinational within cycle c):
  - A LOAD or STORE is accepted iff the free map (registered) is nonzero and no backpressure reject applies.
  - mem2proc_response = lowest-numbered free tag in 1..15; otherwise 0.
- Load accepted in cycle c:
  - The tag is marked busy at the end of c.
  - The array word is read and snapshotted at the end of c; a later store to the same address does not alter the returned value.
  - {valid, tag, data} enters a MEM_LATENCY-deep shift pipeline.
  - In cycle c+MEM_LATENCY, mem2proc_tag=tag and mem2proc_data=data for exactly one cycle. Otherwise mem2proc_tag=0 and mem2proc_data=0.
- Store accepted in cycle c:
  - The array is written at the end of c.
  - A nonzero response is returned but no tag is allocated and no completion is broadcast.
  - A load accepted in cycle c+1 to the same address sees the new value.
- Tag release:
  - The tag broadcast in cycle d is freed at the end of d.
  - It is reallocatable from cycle d+1, never in cycle d itself.
- Throughput: at most one accept and one completion per cycle; the fixed latency guarantees completions never collide.
- Tag exhaustion: with MEM_LATENCY≤14, 15 tags never exhaust under one request per cycle. If all tags are busy, the response is 0 and the requester retries.
- Out-of-range index (addr[63:3] ≥ MEM_WORDS):
  - Accepted normally.
  - Loads return 64'h0.
  - Stores are dropped.
- Idle: command BUS_NONE gives response 0 and no state change except pipeline advance.

Optional Feature:
- MEM_BACKPRESSURE_EN defined:
  - A free-running counter mod BP_PERIOD, reset to 0, advances every cycle.
  - When the counter equals BP_PERIOD-1, any request that cycle gets response 0 and has no side effects, including stores.
- Undefined: the counter is absent and requests are never rejected, except on tag exhaustion.

Decomposition:
- Shared package:
  - BUS_NONE, BUS_LOAD, BUS_STORE command constants.
  - 4-bit mem_tag_t with MEM_TAG_NONE=0.
  - Pipeline entry struct {valid, tag, data}.
- One sub-module, mem_tag_alloc, contains:
  - the 15-bit free map;
  - the lowest-free priority encoder;
  - alloc and release ports, with release taking effect next cycle.

Test Plan:
- Reset, then LOAD addr 0x40 held one cycle with array[8]=0xAAAA → response 1 that cycle; tag=1 and data=0xAAAA exactly MEM_LATENCY=4 cycles later; tag=0 on all other cycles.
- Back-to-back LOADs to addrs 0x0, 0x8, 0x10 over three cycles → responses 1, 2, 3; completions in cycles c+4, c+5, c+6 in that order with matching data.
- STORE 0x1234 to addr 0x80 in cycle c, then LOAD 0x80 in c+1 → load returns 0x1234. LOAD 0x80 in c followed by STORE in c+1 → load returns the old value.
- Tag reuse: a continuous LOAD stream for 20 cycles → tag 1 is reallocated no earlier than one cycle after its broadcast; the response is never 0.
- Reset asserted while two loads are in flight → no nonzero mem2proc_tag after reset; the first post-reset load gets tag 1.
- With MEM_BACKPRESSURE_EN and BP_PERIOD=5 → a request in counter slot 4 gets response 0 and its store is not written; the retry next cycle is accepted.

Source files
------------

// File: rtl/bus_mem_responder_pkg.sv
// Shared definitions for the tagged processor-bus memory responder.
// Bus command encodings, the 4-bit transaction tag type and the load
// return pipeline entry used by bus_mem_responder and mem_tag_alloc.
package bus_mem_responder_pkg;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef logic [3:0] mem_tag_t;
   localparam mem_tag_t MEM_TAG_NONE = 4'd0;

   // One slot of the fixed-latency load return pipeline. Empty slots are
   // kept all-zero so the last slot can drive the outputs directly.
   typedef struct packed {
      logic        valid;
      mem_tag_t    tag;
      logic [63:0] data;
   } pipe_entry_t;

endpackage

// File: rtl/bus_mem_responder_mem_tag_alloc.sv
// Transaction tag allocator for bus_mem_responder.
// Keeps a free map of tags 1..15 and offers the lowest-numbered free tag.
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   alloc_en          : take free_tag at the end of this cycle
//   release_en        : return release_tag at the end of this cycle
//   release_tag       : tag being returned (nonzero)
//   free_tag          : lowest free tag, 0 when none is free
//   any_free          : at least one tag is free
// The offer is computed from the registered map only, so a tag released
// this cycle becomes visible to the allocator one cycle later.
module mem_tag_alloc
   import bus_mem_responder_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       alloc_en,
   input  logic       release_en,
   input  logic [3:0] release_tag,
   output logic [3:0] free_tag,
   output logic       any_free
);

   logic [15:1] free_q;
   logic [15:1] free_d;

   // Lowest-free priority encoder: scan downwards so the lowest set bit wins.
   always_comb begin
      free_tag = MEM_TAG_NONE;
      for (int t = 15; t >= 1; t--) begin
         if (free_q[t]) free_tag = mem_tag_t'(t);
      end
      any_free = |free_q;
   end

   // A released tag is busy in free_q, so it can never equal free_tag here.
   always_comb begin
      free_d = free_q;
      if (alloc_en && any_free) free_d[free_tag] = 1'b0;
      if (release_en && (release_tag != MEM_TAG_NONE)) free_d[release_tag] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) free_q <= '1;
      else       free_q <= free_d;
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the tagged processor bus.
// Accepts BUS_LOAD / BUS_STORE, answers in the same cycle with a nonzero
// tag (or 0 to reject) and returns load data MEM_LATENCY cycles later.
// Ports:
//   clock, reset        : system clock, synchronous active-high reset
//   proc2mem_command    : BUS_NONE / BUS_LOAD / BUS_STORE (3 acts as NONE)
//   proc2mem_addr       : byte address, bits [2:0] ignored
//   proc2mem_data       : store data
//   mem2proc_response   : combinational tag of the accepted request, 0 = reject
//   mem2proc_data       : registered load return data
//   mem2proc_tag        : registered, nonzero for one cycle per completed load
// Build option: define MEM_BACKPRESSURE_EN to reject every request in one
// cycle out of each BP_PERIOD (free-running counter slot BP_PERIOD-1).
//
// Handshake: a request is presented for one cycle; it is taken iff
// mem2proc_response is nonzero in that same cycle, otherwise the requester
// retries later. A load completes exactly MEM_LATENCY cycles after it was
// taken, when mem2proc_tag shows its tag alongside mem2proc_data.
module bus_mem_responder
   import bus_mem_responder_pkg::*;
#(
   parameter int MEM_WORDS   = 4096,
   parameter int MEM_LATENCY = 4,
   parameter int BP_PERIOD   = 5
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [63:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   logic [63:0]      mem_array [MEM_WORDS];
   pipe_entry_t      pipe_q [MEM_LATENCY];
   pipe_entry_t      pipe_d [MEM_LATENCY];
   logic [IDX_W-1:0] idx;
   logic             in_range;
   logic             is_req;
   logic             accept;
   logic             load_acc;
   logic             store_acc;
   logic             bp_block;
   logic [3:0]       free_tag;
   logic             any_free;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^proc2mem_addr[2:0];

`ifdef MEM_BACKPRESSURE_EN
   logic [3:0] bp_cnt_q;
   logic [3:0] bp_cnt_d;

   always_comb begin
      bp_cnt_d = (bp_cnt_q == 4'(BP_PERIOD - 1)) ? 4'd0 : bp_cnt_q + 4'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) bp_cnt_q <= 4'd0;
      else       bp_cnt_q <= bp_cnt_d;
   end

   assign bp_block = (bp_cnt_q == 4'(BP_PERIOD - 1));
`else
   localparam int unused_bp_period = BP_PERIOD;
   assign bp_block = 1'b0;
`endif

   assign idx      = proc2mem_addr[IDX_W+2:3];
   assign in_range = proc2mem_addr[63:3] < 61'(MEM_WORDS);

   // Rejected requests (reset, backpressure, no free tag) have no side effects.
   always_comb begin
      is_req            = (proc2mem_command == BUS_LOAD) || (proc2mem_command == BUS_STORE);
      accept            = !reset && is_req && any_free && !bp_block;
      mem2proc_response = accept ? free_tag : MEM_TAG_NONE;
      load_acc          = accept && (proc2mem_command == BUS_LOAD);
      store_acc         = accept && (proc2mem_command == BUS_STORE) && in_range;
   end

   mem_tag_alloc u_tag_alloc (
      .clock       (clock),
      .reset       (reset),
      .alloc_en    (load_acc),
      .release_en  (pipe_q[MEM_LATENCY-1].valid),
      .release_tag (pipe_q[MEM_LATENCY-1].tag),
      .free_tag    (free_tag),
      .any_free    (any_free)
   );

   // Stores only allocate a response tag; the array is the single point of
   // update. The load snapshot is taken here, before any later store lands.
   always_ff @(posedge clock) begin
      if (store_acc) mem_array[idx] <= proc2mem_data;
   end

   always_comb begin
      pipe_d[0] = '0;
      if (load_acc) begin
         pipe_d[0].valid = 1'b1;
         pipe_d[0].tag   = free_tag;
         pipe_d[0].data  = in_range ? mem_array[idx] : 64'h0;
      end
      for (int i = 1; i < MEM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   // The last pipeline slot is the output register; empty slots are zero.
   assign mem2proc_tag  = pipe_q[MEM_LATENCY-1].tag;
   assign mem2proc_data = pipe_q[MEM_LATENCY-1].data;

endmodule
